// File: rtl/mu_pkg.sv
// Shared constants and types for the MU bus responder and its multiplier.
package mu_pkg;

  localparam logic [26:0] MU_BASE    = 27'h2000000;
  localparam int          MUL_CYCLES = 32;

  localparam logic [26:0] OFS_MUL_A    = 27'h0;
  localparam logic [26:0] OFS_MUL_B    = 27'h1;
  localparam logic [26:0] OFS_MUL_LO   = 27'h2;
  localparam logic [26:0] OFS_MUL_HI   = 27'h3;
  localparam logic [26:0] OFS_CYC_LO   = 27'h4;
  localparam logic [26:0] OFS_CYC_HI   = 27'h5;
  localparam logic [26:0] OFS_TMR      = 27'h6;
  localparam logic [26:0] OFS_TMR_CTRL = 27'h7;
  localparam logic [26:0] OFS_SCRATCH  = 27'h8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MUL,
    DONE
  } mu_state_t;

endpackage

// File: rtl/mu_multiplier.sv
// Iterative 32x32->64 unsigned shift-add multiplier; one partial product per cycle.
module mu_multiplier
  import mu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [63:0] product,
  output logic        finish
);

  localparam int CW = $clog2(MUL_CYCLES);

  logic [CW-1:0] iter, iter_in;
  logic [63:0]   acc, acc_in, acc_nxt, mcand, mcand_in;
  logic [31:0]   mplier, mplier_in;

  // Iteration 0 runs on the start edge straight from the operand inputs.
  always_comb begin
    if (start) begin
      acc_in    = '0;
      mcand_in  = {32'b0, a};
      mplier_in = b;
      iter_in   = '0;
    end else begin
      acc_in    = acc;
      mcand_in  = mcand;
      mplier_in = mplier;
      iter_in   = iter;
    end
    acc_nxt = acc_in + (mplier_in[0] ? mcand_in : 64'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter    <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      busy    <= 1'b0;
      product <= '0;
      finish  <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (start || busy) begin
        acc    <= acc_nxt;
        mcand  <= mcand_in << 1;
        mplier <= mplier_in >> 1;
        iter   <= iter_in + 1'b1;
        busy   <= 1'b1;
        if (iter_in == CW'(MUL_CYCLES - 1)) begin
          busy    <= 1'b0;
          product <= acc_nxt;
          finish  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mu_responder.sv
// MU bus responder: register file, multiplier host, cycle counter and one-shot timer.
//   state  | meaning
//   IDLE   | ready, waiting for a start strobe
//   ACCESS | register read/write, q latched
//   MUL    | waiting for the multiplier to finish
//   DONE   | done pulse, then back to IDLE
module mu_responder
  import mu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [26:0] bus_mu_addr,
  input  logic        bus_mu_start,
  input  logic [31:0] bus_mu_data,
  input  logic        bus_mu_we,
  output logic [31:0] bus_mu_q,
  output logic        bus_mu_done,
  output logic        bus_mu_ready,
  output logic        timer_int
);

  mu_state_t   state;
  logic [26:0] addr_r, ofs;
  logic        we_r;
  logic [31:0] data_r, rdata;
  logic [31:0] mul_a, mul_b, cyc_shadow, tmr_load, tmr_count;
  logic [63:0] cyc, mul_product;
  logic [31:0] scratch [8];
  logic        tmr_en, tmr_flag;
  logic        mul_start, mul_busy, mul_finish, tmr_ctrl_we, tmr_expire, is_scratch;

  assign ofs         = addr_r - MU_BASE;
  assign is_scratch  = (ofs[26:3] == OFS_SCRATCH[26:3]);
  assign mul_start   = (state == ACCESS) && we_r && (ofs == OFS_MUL_LO) && !mul_busy;
  assign tmr_ctrl_we = (state == ACCESS) && we_r && (ofs == OFS_TMR_CTRL);
  assign tmr_expire  = tmr_en && (tmr_count <= 32'd1);

  mu_multiplier u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .product (mul_product),
    .finish  (mul_finish)
  );

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_MUL_A:    rdata = mul_a;
      OFS_MUL_B:    rdata = mul_b;
      OFS_MUL_LO:   rdata = mul_product[31:0];
      OFS_MUL_HI:   rdata = mul_product[63:32];
      OFS_CYC_LO:   rdata = cyc[31:0];
      OFS_CYC_HI:   rdata = cyc_shadow;
      OFS_TMR:      rdata = tmr_count;
      OFS_TMR_CTRL: rdata = {30'b0, tmr_flag, tmr_en};
      default:      if (is_scratch) rdata = scratch[ofs[2:0]];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      addr_r       <= '0;
      we_r         <= 1'b0;
      data_r       <= '0;
      bus_mu_q     <= '0;
      bus_mu_done  <= 1'b0;
      bus_mu_ready <= 1'b1;
      mul_a        <= '0;
      mul_b        <= '0;
      cyc_shadow   <= '0;
      tmr_load     <= '0;
      for (int i = 0; i < 8; i++) scratch[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_mu_start) begin
            addr_r       <= bus_mu_addr;
            we_r         <= bus_mu_we;
            data_r       <= bus_mu_data;
            bus_mu_ready <= 1'b0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (we_r) begin
            case (ofs)
              OFS_MUL_A: mul_a    <= data_r;
              OFS_MUL_B: mul_b    <= data_r;
              OFS_TMR:   tmr_load <= data_r;
              default:   if (is_scratch) scratch[ofs[2:0]] <= data_r;
            endcase
          end else begin
            bus_mu_q <= rdata;
            // Upper word is frozen together with the low-word read.
            if (ofs == OFS_CYC_LO) cyc_shadow <= cyc[63:32];
          end
          if (mul_start) begin
            state <= MUL;
          end else begin
            bus_mu_done <= 1'b1;
            state       <= DONE;
          end
        end
        MUL: begin
          if (mul_finish) begin
            bus_mu_q    <= mul_product[31:0];
            bus_mu_done <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          bus_mu_done  <= 1'b0;
          bus_mu_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 64'd1;
  end

  // A control write in the expiry cycle owns enable/flag; the interrupt still fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_count <= '0;
      tmr_en    <= 1'b0;
      tmr_flag  <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      timer_int <= tmr_expire;
      if (tmr_ctrl_we) begin
        tmr_en <= data_r[0];
        if (data_r[1]) tmr_flag <= 1'b0;
      end else if (tmr_expire) begin
        tmr_en   <= 1'b0;
        tmr_flag <= 1'b1;
      end
      if (tmr_ctrl_we && data_r[0]) tmr_count <= tmr_load;
      else if (tmr_en)              tmr_count <= tmr_expire ? 32'd0 : tmr_count - 32'd1;
    end
  end

endmodule

// File: tb/tb_mu_responder.sv
// Self-checking bench for mu_responder: directed cases plus randomized traffic against a
// transaction-level model that predicts done/ready windows, read data and timer pulses.
module tb_mu_responder;

  localparam logic [26:0] BASE = 27'h2000000;

  logic        clk, reset;
  logic [26:0] bus_mu_addr;
  logic        bus_mu_start, bus_mu_we;
  logic [31:0] bus_mu_data, bus_mu_q;
  logic        bus_mu_done, bus_mu_ready, timer_int;

  mu_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus_mu_addr  (bus_mu_addr),
    .bus_mu_start (bus_mu_start),
    .bus_mu_data  (bus_mu_data),
    .bus_mu_we    (bus_mu_we),
    .bus_mu_q     (bus_mu_q),
    .bus_mu_done  (bus_mu_done),
    .bus_mu_ready (bus_mu_ready),
    .timer_int    (timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycles elapsed since reset release; equals the expected free-running counter value.
  longint cyc_n;
  always @(posedge clk or posedge reset)
    if (reset) cyc_n <= 0;
    else       cyc_n <= cyc_n + 1;

  // ---------------- model state ----------------
  bit [31:0] m_a, m_b, m_shadow, m_scr [8];
  bit [63:0] m_prod;
  bit [31:0] t_load, t_L, t_held;
  bit        t_run, t_flag;
  longint    t_s;
  bit        exp_int [longint];
  longint    acc_k, done_k;
  bit [31:0] exp_q;
  bit        exp_q_chk;
  bit        chk_en;

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc_n, act, expv);
    end
  endtask

  function automatic longint t_x();
    return t_s + ((t_L == 0) ? 64'd1 : longint'(t_L));
  endfunction

  function automatic bit [31:0] count_at(input longint c);
    longint v;
    if (!t_run) return t_held;
    if (c >= t_x()) return 32'd0;
    v = longint'(t_L) - (c - t_s);
    return v[31:0];
  endfunction

  function automatic bit flag_at(input longint c);
    return t_flag || (t_run && c >= t_x());
  endfunction

  function automatic bit en_at(input longint c);
    return t_run && c < t_x();
  endfunction

  // Control write that takes effect in cycle c.
  task automatic timer_write(input longint c, input bit [31:0] d);
    if (t_run) begin
      if (t_x() < c) begin
        t_flag = 1'b1;
        t_held = 32'd0;
      end else begin
        t_held = count_at(c);
        if (t_x() > c) exp_int.delete(t_x());
      end
      t_run = 1'b0;
    end
    if (d[1]) t_flag = 1'b0;
    if (d[0]) begin
      t_run = 1'b1;
      t_s   = c;
      t_L   = t_load;
      exp_int[t_x()] = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_shadow = 0; m_prod = 0;
    foreach (m_scr[i]) m_scr[i] = 0;
    t_load = 0; t_L = 0; t_held = 0; t_run = 0; t_flag = 0; t_s = 0;
    exp_int.delete();
    acc_k = -100; done_k = -100;
    exp_q = 0; exp_q_chk = 0;
  endtask

  // Transaction accepted in cycle k.
  task automatic model_access(input longint k, input bit [26:0] addr, input bit we,
                              input bit [31:0] data);
    bit [26:0] ofs;
    bit [63:0] ta, tb, v;
    longint    dur;
    ofs = addr - BASE;
    dur = 2;
    exp_q_chk = !we;
    exp_q = 0;
    if (ofs < 16) begin
      case (int'(ofs))
        0: if (we) m_a = data; else exp_q = m_a;
        1: if (we) m_b = data; else exp_q = m_b;
        2: begin
          if (we) begin
            ta = {32'b0, m_a}; tb = {32'b0, m_b};
            m_prod = ta * tb;
            exp_q_chk = 1'b1;
            dur = 34;
          end
          exp_q = m_prod[31:0];
        end
        3: exp_q = m_prod[63:32];
        4: if (!we) begin
          v = 64'(k + 1);
          exp_q = v[31:0];
          m_shadow = v[63:32];
        end
        5: exp_q = m_shadow;
        6: if (we) t_load = data; else exp_q = count_at(k + 1);
        7: if (we) timer_write(k + 2, data);
           else exp_q = {30'b0, flag_at(k + 1), en_at(k + 1)};
        default: if (we) m_scr[ofs[2:0]] = data; else exp_q = m_scr[ofs[2:0]];
      endcase
    end
    acc_k = k;
    done_k = k + dur;
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("ready", {31'b0, bus_mu_ready}, {31'b0, !(cyc_n > acc_k && cyc_n <= done_k)});
      check("done", {31'b0, bus_mu_done}, {31'b0, cyc_n == done_k});
      check("timer_int", {31'b0, timer_int}, {31'b0, exp_int.exists(cyc_n)});
      if (cyc_n == done_k && exp_q_chk) check("q", bus_mu_q, exp_q);
    end
  end

  // Caller is at a negedge where the responder is expected to be ready.
  task automatic txn(input bit [26:0] addr, input bit we, input bit [31:0] data,
                     input bit stray, output bit [31:0] q_got, output int lat);
    longint k;
    k = cyc_n;
    model_access(k, addr, we, data);
    bus_mu_addr  = addr;
    bus_mu_we    = we;
    bus_mu_data  = data;
    bus_mu_start = 1'b1;
    lat = -1;
    q_got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (stray && cyc_n < done_k && ($urandom % 3 == 0)) begin
        bus_mu_start = 1'b1;
        bus_mu_addr  = BASE + 27'($urandom_range(0, 19));
        bus_mu_we    = $urandom % 2;
        bus_mu_data  = $urandom;
      end else begin
        bus_mu_start = 1'b0;
      end
      if (bus_mu_done) begin
        lat = int'(cyc_n - k);
        q_got = bus_mu_q;
        break;
      end
    end
    bus_mu_start = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout addr %h: no done within 40 cycles", addr);
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    bit [31:0] q;
    int        lat;
    longint    k, got;
    bit [26:0] ofs;
    bit        we;
    bit [31:0] d;

    model_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    bus_mu_start = 1'b0;
    bus_mu_addr = '0;
    bus_mu_we = 1'b0;
    bus_mu_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("reset_q", bus_mu_q, 32'h0);
    check("reset_ready", {31'b0, bus_mu_ready}, 32'd1);
    check("reset_done", {31'b0, bus_mu_done}, 32'd0);
    check("reset_timer_int", {31'b0, timer_int}, 32'd0);

    // Scratch write/readback
    txn(27'h200000A, 1'b1, 32'h1234_5678, 1'b0, q, lat);
    check("scratch_wr_latency", lat, 2);
    txn(27'h200000A, 1'b0, 32'h0, 1'b0, q, lat);
    check("scratch_rd_latency", lat, 2);
    check("scratch_rd_q", q, 32'h1234_5678);

    // Full-range multiply with stray starts during MUL
    txn(BASE + 27'h0, 1'b1, 32'hFFFF_FFFF, 1'b0, q, lat);
    txn(BASE + 27'h1, 1'b1, 32'hFFFF_FFFF, 1'b0, q, lat);
    txn(BASE + 27'h2, 1'b1, 32'hDEAD_BEEF, 1'b1, q, lat);
    check("mul_latency", lat, 34);
    check("mul_q", q, 32'h0000_0001);
    txn(BASE + 27'h3, 1'b0, 32'h0, 1'b0, q, lat);
    check("mul_hi", q, 32'hFFFF_FFFE);
    txn(BASE + 27'h2, 1'b0, 32'h0, 1'b0, q, lat);
    check("mul_lo_reread", q, 32'h0000_0001);

    // Cycle counter low then shadowed high
    txn(BASE + 27'h4, 1'b0, 32'h0, 1'b0, q, lat);
    txn(BASE + 27'h5, 1'b0, 32'h0, 1'b0, q, lat);
    check("cyc_hi_shadow", q, 32'h0);

    // One-shot timer
    txn(BASE + 27'h6, 1'b1, 32'd5, 1'b0, q, lat);
    k = cyc_n;
    txn(BASE + 27'h7, 1'b1, 32'd1, 1'b0, q, lat);
    got = -1;
    for (int i = 0; i < 20; i++) begin
      if (timer_int) begin
        got = cyc_n;
        break;
      end
      @(negedge clk);
    end
    check("timer_pulse_cycle", 32'(got - k), 32'd7);
    @(negedge clk);
    txn(BASE + 27'h7, 1'b0, 32'h0, 1'b0, q, lat);
    check("tmr_ctrl_expired", q, 32'h2);
    txn(BASE + 27'h7, 1'b1, 32'h2, 1'b0, q, lat);
    txn(BASE + 27'h7, 1'b0, 32'h0, 1'b0, q, lat);
    check("tmr_ctrl_cleared", q, 32'h0);

    // Unmapped offset
    txn(27'h2000010, 1'b0, 32'h0, 1'b0, q, lat);
    check("unmapped_q", q, 32'h0);
    check("unmapped_latency", lat, 2);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ofs = 27'($urandom_range(0, 19));
      we = $urandom % 2;
      if (ofs == 6)      d = $urandom_range(0, 40);
      else if (ofs == 7) d = $urandom_range(0, 3);
      else               d = $urandom;
      txn(BASE + ofs, we, d, $urandom % 2, q, lat);
    end

    // Reset in the middle of a multiply
    txn(BASE + 27'h0, 1'b1, 32'h0001_2345, 1'b0, q, lat);
    txn(BASE + 27'h1, 1'b1, 32'h0006_7890, 1'b0, q, lat);
    model_access(cyc_n, BASE + 27'h2, 1'b1, 32'h0);
    bus_mu_addr = BASE + 27'h2;
    bus_mu_we = 1'b1;
    bus_mu_start = 1'b1;
    @(negedge clk);
    bus_mu_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_ready", {31'b0, bus_mu_ready}, 32'd1);
    check("abort_done", {31'b0, bus_mu_done}, 32'd0);
    repeat (40) @(negedge clk);
    txn(BASE + 27'h2, 1'b0, 32'h0, 1'b0, q, lat);
    check("abort_mul_lo", q, 32'h0);
    txn(BASE + 27'h3, 1'b0, 32'h0, 1'b0, q, lat);
    check("abort_mul_hi", q, 32'h0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mu_responder.md
# mu_responder

Responder end of the CPU data-side Memory Unit (MU) bus: accepts single-word transactions addressed at or above 0x2000000 and completes them with a `bus_mu_done` pulse. Hosts a 32-cycle iterative multiplier, a 64-bit cycle counter, a one-shot countdown timer and eight scratch words. Sits between the CPU data-memory arbiter and the interrupt controller, which receives `timer_int`.

## Interface
- `MU_BASE`, 27'h2000000: byte-free word address of offset 0.
- `MUL_CYCLES`, 32: multiplier iterations; fixed, not for override.
- `clk` in 1: system clock, single domain.
- `reset` in 1: asynchronous, active-high.
- `bus_mu_addr` in 27: word address, sampled on an accepted start.
- `bus_mu_start` in 1: one-cycle request strobe.
- `bus_mu_data` in 32: write data, sampled on an accepted start.
- `bus_mu_we` in 1: 1 = write, 0 = read, sampled on an accepted start.
- `bus_mu_q` out 32: read data; valid in the done cycle, held until the next done.
- `bus_mu_done` out 1: one-cycle completion pulse.
- `bus_mu_ready` out 1: high only in IDLE; start is accepted only when high.
- `timer_int` out 1: one-cycle pulse when the timer expires.

## Operation
- Offset is `bus_mu_addr - MU_BASE`. Map:
  - 0x0 MUL_A: rw.
  - 0x1 MUL_B: rw.
  - 0x2 MUL_LO: read returns product[31:0]; a write of any value starts A×B unsigned.
  - 0x3 MUL_HI: ro, product[63:32].
  - 0x4 CYC_LO: ro. A read also snapshots counter[63:32] into a shadow register.
  - 0x5 CYC_HI: ro, returns the shadow.
  - 0x6 TMR: write sets the load value; read returns the current count.
  - 0x7 TMR_CTRL: bit0 = enable, bit1 = expired flag. Writing bit0=1 loads count from the load value and enables. Writing bit1=1 clears the flag. Read returns {30'b0, flag, enable}.
  - 0x8–0xF: scratch, rw.
  - Offset ≥ 0x10: reads return 0, writes ignored, normal latency.
- Writes to read-only offsets are ignored.
- States:
  - IDLE: ready=1. start → ACCESS, latching addr/we/data.
  - ACCESS: performs the register read or write and latches q. A write to 0x2 → MUL; otherwise → DONE.
  - MUL: shift-add one bit per cycle, iteration counter 0..31. After iteration 31 → DONE, with q = product low word.
  - DONE: done=1 → IDLE.
- Product registers are updated only at multiply completion. Reads of 0x2/0x3 return the last completed product.
- Cycle counter: 64-bit, increments every cycle, wraps 2^64−1 → 0.
- Timer: while enabled, count decrements once per cycle. On the decrement to 0:
  - flag set, `timer_int` pulses for 1 cycle, enable cleared (one-shot).
  - A load of 0 expires on the first enabled cycle.
  - A write to TMR_CTRL in the expiry cycle wins over the expiry flag set, except that `timer_int` still pulses.
- Timer and cycle counter run independently of bus state.

## Timing
- Start accepted at cycle T (IDLE): ready=0 at T+1, done=1 at T+2, ready=1 at T+3. Earliest next accept is T+3.
- Multiply start write: done at T+2+MUL_CYCLES = T+34.
- Start while ready=0 is ignored: no queuing, no side effects.
- Reset values:
  - q=0, done=0, ready=1, timer_int=0.
  - All registers, counters, shadow and flag = 0.
  - State = IDLE.
- Reset mid-transaction aborts it: no done is issued, and any partial product is discarded.

## Structure
- Shared package `mu_pkg`: `MU_BASE`, offset constants (OFS_MUL_A … OFS_SCRATCH), state enum (IDLE, ACCESS, MUL, DONE), `MUL_CYCLES`.
- Sub-module `mu_multiplier`: iterative 32×32→64 unsigned shift-add.
  - Ports: clk, reset, start, a, b, busy, product, finish.
  - The top FSM waits on `finish`.

## Test plan
- Reset, then write 0x1234_5678 to 0x200000A and read it back: done at T+2 for each; q=0x12345678; ready low for exactly 2 cycles per access.
- MUL_A=0xFFFF_FFFF, MUL_B=0xFFFF_FFFF, write 0x2: done at T+34 with q=0x0000_0001. Reading 0x3 then returns 0xFFFF_FFFE.
- Start pulsed during MUL: ignored, result unchanged, exactly one done.
- Read 0x4 then 0x5 across a low-word wrap: {HI,LO} is consistent, and HI equals the upper word at the time LO was read.
- TMR=5, TMR_CTRL=1: timer_int pulses 5 cycles after the write takes effect. TMR_CTRL reads 0x2. Writing 0x2 clears it to 0x0.
- Read 0x2000010: q=0, done at T+2. Assert reset during MUL: no done, ready=1, MUL_LO reads 0.
